// File: rtl/lms_if_pkg.sv
// Shared definitions for the LMS IQ front end: TX test-mode encodings and
// the width of the RX IQSEL error counters.
package lms_if_pkg;

  localparam int ERR_W = 16;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_LOOP   = 2'd3
  } tx_mode_e;

endpackage

// File: rtl/lms_rx_deint.sv
// Single-channel RX path: pad registers, I/Q deinterleave into aligned pairs,
// and IQSEL alignment monitoring (lock flag plus saturating error counter).
module lms_rx_deint
  import lms_if_pkg::*;
#(
  parameter int DW       = 12,
  parameter int RX_I_POL = 1,
  parameter int LOCK_LEN = 16
) (
  input  logic             lms_clk,
  input  logic             reset_n,
  input  logic             rx_iqsel,
  input  logic [DW-1:0]    rx_d,
  input  logic             swap_iq,
  input  logic             clear_err,
  output logic             adc_strobe,
  output logic [DW-1:0]    adc_i,
  output logic [DW-1:0]    adc_q,
  output logic             rx_locked,
  output logic [ERR_W-1:0] rx_err_cnt
);

  localparam logic       I_LVL    = RX_I_POL[0];
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_LEN);

  logic          iq_r, iq_p;
  logic [DW-1:0] d_r;
  logic          r_seen, p_seen;
  logic [DW-1:0] i_hold;
  logic          i_valid;
  logic [7:0]    lc;

  // r_seen/p_seen mark when iq_r/iq_p hold real pad samples rather than reset values
  always_ff @(posedge lms_clk or negedge reset_n) begin
    if (!reset_n) begin
      iq_r   <= 1'b0;
      iq_p   <= 1'b0;
      d_r    <= '0;
      r_seen <= 1'b0;
      p_seen <= 1'b0;
    end else begin
      iq_r   <= rx_iqsel;
      d_r    <= rx_d;
      iq_p   <= iq_r;
      r_seen <= 1'b1;
      p_seen <= r_seen;
    end
  end

  always_ff @(posedge lms_clk or negedge reset_n) begin
    if (!reset_n) begin
      i_hold     <= '0;
      i_valid    <= 1'b0;
      adc_i      <= '0;
      adc_q      <= '0;
      adc_strobe <= 1'b0;
    end else begin
      adc_strobe <= 1'b0;
      if (r_seen) begin
        if (iq_r == I_LVL) begin
          i_hold  <= d_r;
          i_valid <= 1'b1;
        end else if (i_valid) begin
          adc_i      <= swap_iq ? d_r : i_hold;
          adc_q      <= swap_iq ? i_hold : d_r;
          adc_strobe <= 1'b1;
          i_valid    <= 1'b0;
        end
      end
    end
  end

  // A clear in the same cycle as a non-toggle wins over the increment
  always_ff @(posedge lms_clk or negedge reset_n) begin
    if (!reset_n) begin
      lc         <= '0;
      rx_locked  <= 1'b0;
      rx_err_cnt <= '0;
    end else begin
      if (p_seen) begin
        if (iq_r != iq_p) begin
          if (lc != LOCK_MAX) lc <= lc + 8'd1;
          if (lc == LOCK_MAX) rx_locked <= 1'b1;
        end else begin
          lc        <= '0;
          rx_locked <= 1'b0;
          if (rx_err_cnt != '1) rx_err_cnt <= rx_err_cnt + 1'b1;
        end
      end
      if (clear_err) rx_err_cnt <= '0;
    end
  end

endmodule

// File: rtl/lms_iq_frontend.sv
// Multi-channel bridge between the LMS interleaved IQ pads and the DSP core:
// per-channel RX deinterleave instances plus a shared-phase TX interleaver.
module lms_iq_frontend
  import lms_if_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DW       = 12,
  parameter int RX_I_POL = 1,
  parameter int TX_I_POL = 0,
  parameter int LOCK_LEN = 16
) (
  input  logic                    lms_clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       rx_iqsel,
  input  logic [NUM_CH*DW-1:0]    rx_d,
  input  logic [NUM_CH-1:0]       swap_iq,
  input  logic                    clear_err,
  output logic [NUM_CH-1:0]       adc_strobe,
  output logic [NUM_CH*DW-1:0]    adc_i,
  output logic [NUM_CH*DW-1:0]    adc_q,
  output logic [NUM_CH-1:0]       rx_locked,
  output logic [NUM_CH*ERR_W-1:0] rx_err_cnt,
  input  logic                    tx_enable,
  input  logic [2*NUM_CH-1:0]     tx_mode,
  input  logic [NUM_CH*DW-1:0]    dac_i,
  input  logic [NUM_CH*DW-1:0]    dac_q,
  output logic                    dac_strobe,
  output logic [NUM_CH-1:0]       tx_iqsel,
  output logic [NUM_CH*DW-1:0]    tx_d,
  output logic [NUM_CH-1:0]       tx_en
);

  localparam logic TX_I_LVL = TX_I_POL[0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_rx
    lms_rx_deint #(
      .DW       (DW),
      .RX_I_POL (RX_I_POL),
      .LOCK_LEN (LOCK_LEN)
    ) u_rx (
      .lms_clk    (lms_clk),
      .reset_n    (reset_n),
      .rx_iqsel   (rx_iqsel[c]),
      .rx_d       (rx_d[c*DW +: DW]),
      .swap_iq    (swap_iq[c]),
      .clear_err  (clear_err),
      .adc_strobe (adc_strobe[c]),
      .adc_i      (adc_i[c*DW +: DW]),
      .adc_q      (adc_q[c*DW +: DW]),
      .rx_locked  (rx_locked[c]),
      .rx_err_cnt (rx_err_cnt[c*ERR_W +: ERR_W])
    );
  end

  logic                 tx_phase;
  logic [DW-1:0]        ramp;
  logic [NUM_CH*DW-1:0] q_held;
  logic [NUM_CH*DW-1:0] src_i, src_q;

  // Gated by reset_n so the strobe is low while the block is held in reset
  assign dac_strobe = tx_enable & ~tx_phase & reset_n;

  always_comb begin
    src_i = '0;
    src_q = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (tx_mode_e'(tx_mode[2*c +: 2]))
        MODE_NORMAL: begin
          src_i[c*DW +: DW] = dac_i[c*DW +: DW];
          src_q[c*DW +: DW] = dac_q[c*DW +: DW];
        end
        MODE_ZERO: begin
          src_i[c*DW +: DW] = '0;
          src_q[c*DW +: DW] = '0;
        end
        MODE_RAMP: begin
          src_i[c*DW +: DW] = ramp;
          src_q[c*DW +: DW] = ~ramp;
        end
        default: begin
          src_i[c*DW +: DW] = adc_i[c*DW +: DW];
          src_q[c*DW +: DW] = adc_q[c*DW +: DW];
        end
      endcase
    end
  end

  // Both words of a pair are captured together in phase 0 so a pair never tears
  always_ff @(posedge lms_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_phase <= 1'b0;
      ramp     <= '0;
      q_held   <= '0;
      tx_d     <= '0;
      tx_iqsel <= '0;
      tx_en    <= '0;
    end else if (!tx_enable) begin
      tx_phase <= 1'b0;
      tx_d     <= '0;
      tx_iqsel <= '0;
      tx_en    <= '0;
    end else begin
      tx_phase <= ~tx_phase;
      tx_en    <= '1;
      if (!tx_phase) begin
        tx_d     <= src_i;
        q_held   <= src_q;
        tx_iqsel <= {NUM_CH{TX_I_LVL}};
        ramp     <= ramp + 1'b1;
      end else begin
        tx_d     <= q_held;
        tx_iqsel <= {NUM_CH{~TX_I_LVL}};
      end
    end
  end

endmodule
